// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter states, data-length limits and stop-bit codes
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int   MIN_DATA_LEN = 5;
    localparam logic STOP_ONE     = 1'b0;
    localparam logic STOP_TWO     = 1'b1;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
        if (int'(len) < MIN_DATA_LEN) return 4'(MIN_DATA_LEN);
        if (int'(len) > max_len)      return 4'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - transmit buffer write port with ready and level status
interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 4
);
    logic                  tx_data_reg_wr;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic [PTR_WIDTH-1:0]  tx_fifo_level;

    modport master (
        output tx_data_reg_wr,
        output tx_data,
        input  tx_ready,
        input  tx_fifo_level
    );

    modport slave (
        input  tx_data_reg_wr,
        input  tx_data,
        output tx_ready,
        output tx_fifo_level
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; writes while full are dropped, reads only when non-empty
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 wr_valid,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 wr_ready,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WIDTH-1:0]     rd_data,
    output logic [PTR_WIDTH-1:0] level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]        LAST = AW'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] FULL = PTR_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [PTR_WIDTH-1:0] count;
    logic                 push, pop;

    assign wr_ready = (count != FULL);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign level    = count;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_ready && rd_valid;

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + PTR_WIDTH'(1);
                2'b01:   count <= count - PTR_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - buffered UART transmitter with run-time length, parity and stop-bit framing
// Optional line-break control is built only when UART_TX_BREAK_EN is defined.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = 4
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    input  logic           tx_baud_pulse,
    uart_tx_param_if.slave wr_if,
    input  logic [3:0]     data_len,
    input  logic           stop_bits,
    input  logic           parity_en,
    input  logic           parity_odd0_even1,
`ifdef UART_TX_BREAK_EN
    input  logic           tx_break,
`endif
    output logic           UART_TX,
    output logic           tx_busy,
    output logic           tx_done
);
    uart_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, fifo_rd_data;
    logic [3:0]            cnt_q, cnt_d, len_q, len_d, len_eff;
    logic                  stop2_q, stop2_d, par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic                  fifo_rd_valid, pop, brk, line_d, par_calc, stop_last;

`ifdef UART_TX_BREAK_EN
    assign brk = tx_break;
`else
    assign brk = 1'b0;
`endif

    sync_fifo #(
        .WIDTH     (DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .wr_valid (wr_if.tx_data_reg_wr),
        .wr_data  (wr_if.tx_data),
        .wr_ready (wr_if.tx_ready),
        .rd_valid (fifo_rd_valid),
        .rd_ready (pop),
        .rd_data  (fifo_rd_data),
        .level    (wr_if.tx_fifo_level)
    );

    assign len_eff   = clamp_len(data_len, DATA_WIDTH);
    assign stop_last = (stop2_q == STOP_ONE) || (cnt_q == 4'd1);
    assign tx_busy   = (state_q != ST_IDLE);

    // Parity covers only the bits that will actually be shifted out.
    always_comb begin
        par_calc = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(len_eff)) par_calc = par_calc ^ fifo_rd_data[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        stop2_d   = stop2_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        pop       = 1'b0;
        tx_done   = 1'b0;
        if (tx_baud_pulse) begin
            case (state_q)
                ST_IDLE:   pop = fifo_rd_valid && !brk;
                ST_START:  state_d = ST_DATA;
                ST_DATA: begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == len_q - 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    if (stop_last) begin
                        cnt_d   = 4'd0;
                        tx_done = 1'b1;
                        state_d = ST_IDLE;
                        // Chain straight into the next START so frames stay gapless.
                        pop     = fifo_rd_valid && !brk;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
            if (pop) begin
                state_d   = ST_START;
                shift_d   = fifo_rd_data;
                cnt_d     = 4'd0;
                len_d     = len_eff;
                stop2_d   = stop_bits;
                par_en_d  = parity_en;
                par_bit_d = par_calc ^ ~parity_odd0_even1;
            end
        end
    end

    // Line value tracks the state being entered so each bit aligns with its baud period.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = par_bit_d;
            default:   line_d = 1'b1;
        endcase
        if (brk) line_d = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= 4'd0;
            len_q     <= 4'(MIN_DATA_LEN);
            stop2_q   <= STOP_ONE;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            UART_TX   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            stop2_q   <= stop2_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            UART_TX   <= line_d;
        end
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8: maximum data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 8: transmit buffer entries.
REQ-003 Parameter PTR_WIDTH, default 4: FIFO pointer and level width; FIFO_DEPTH < 2**PTR_WIDTH.
REQ-004 ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 ARESETn  in  1  asynchronous active-low reset.
REQ-006 tx_baud_pulse  in  1  one-cycle tick per bit period.
REQ-007 tx_data_reg_wr  in  1  push tx_data into FIFO.
REQ-008 tx_data  in  DATA_WIDTH  word to send, LSB first.
REQ-009 data_len  in  4  data bits per frame; values <5 are treated as 5, values >DATA_WIDTH as DATA_WIDTH.
REQ-010 stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
REQ-011 parity_en  in  1  insert parity bit after data.
REQ-012 parity_odd0_even1  in  1  parity sense.
REQ-013 tx_break  in  1  force line low (present only with UART_TX_BREAK_EN).
REQ-014 UART_TX  out  1  serial line, registered.
REQ-015 tx_ready  out  1  FIFO not full.
REQ-016 tx_busy  out  1  state != IDLE.
REQ-017 tx_done  out  1  one-cycle pulse at end of the last stop bit.
REQ-018 tx_fifo_level  out  PTR_WIDTH  current FIFO occupancy.

Function
REQ-019 States: IDLE, START, DATA, PARITY, STOP; state advances only in cycles with tx_baud_pulse=1.
REQ-020 IDLE->START when FIFO non-empty and tx_baud_pulse=1; that cycle pops one word into a DATA_WIDTH shift register.
REQ-021 START->DATA; DATA stays for data_len pulses, then ->PARITY if parity_en, else ->STOP.
REQ-022 PARITY->STOP; STOP stays for 1 or 2 pulses per stop_bits, then ->IDLE with tx_done=1 in the transition cycle.
REQ-023 UART_TX is registered from the current state: IDLE 1, START 0, DATA shift-register bit 0 (shift right per pulse), PARITY, STOP 1; each bit lasts exactly one baud period.
REQ-024 Parity is computed over the data_len bits sent only: even-mode bit = XOR of those bits; odd-mode bit = its inverse.
REQ-025 data_len, stop_bits, parity_en and parity_odd0_even1 are sampled at the IDLE->START pop and held for the whole frame.
REQ-026 A write while the FIFO is full is discarded; FIFO contents and level are unchanged.
REQ-027 A write and a pop in the same cycle leave tx_fifo_level unchanged.
REQ-028 A write to an empty FIFO is not popped in the same cycle; it is eligible from the next tx_baud_pulse.
REQ-029 Back-to-back frames: the START state directly follows the final STOP period when data is queued (one IDLE pulse period between frames is not permitted).
REQ-030 The bit counter wraps to 0 on every DATA exit; no residue carries into the next frame.

Reset
REQ-031 On ARESETn=0: state IDLE, UART_TX=1, tx_busy=0, tx_done=0, tx_fifo_level=0, tx_ready=1, FIFO emptied, shift register 0.
REQ-032 Reset asserted mid-frame aborts the frame immediately; the line returns to 1 without a stop bit.

Configuration
REQ-033 With UART_TX_BREAK_EN defined: tx_break=1 forces UART_TX=0 from the next cycle, and in IDLE it blocks pops.
REQ-034 With UART_TX_BREAK_EN defined: if tx_break rises mid-frame, the frame completes internally, the line stays 0, and tx_done still pulses.
REQ-035 Without UART_TX_BREAK_EN: port tx_break and its logic are absent.

Structure
REQ-036 State encodings, the minimum data length (5) and the stop-bit codes live in shared package uart_pkg.
REQ-037 The buffer is one instance of sub-module sync_fifo, with rd_ready driven by the IDLE pop condition.

Verification
REQ-038 DATA_WIDTH=8, data_len=8, no parity, 1 stop, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 per baud period; tx_done once.
REQ-039 data_len=7, parity even, 2 stop, write 0x53 -> bits 0,1,1,0,0,1,0,1,0,1,1; parity bit = 0 (four ones).
REQ-040 Nine writes with no baud pulses at FIFO_DEPTH=8 -> level 8, tx_ready=0, ninth word dropped; eight frames sent back-to-back.
REQ-041 data_len=3 at DATA_WIDTH=8 -> five data bits sent; data_len=12 -> eight data bits sent.
REQ-042 Reset pulse during the DATA bit 3 of a frame -> UART_TX=1, level=0, tx_busy=0 immediately; no tx_done.
REQ-043 UART_TX_BREAK_EN: tx_break=1 with 2 words queued -> line 0 and no pops; on release, both frames are sent in order.
